// File: rtl/speed_pulse_gen.sv
// Encoder pulse emulator: spreads `rate` pulses evenly over a window of WINDOW clocks
// with a phase accumulator and reports how many pulses the last full window emitted.
module speed_pulse_gen #(
    parameter int unsigned WINDOW   = 1000000,
    parameter int unsigned HIGH_CYC = 4
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        en,
    input  logic [11:0] rate,
    output logic        speed_pulse,
    output logic        window_done,
    output logic [11:0] pulse_cnt
);
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUN_LOW  = 2'b01,
        RUN_HIGH = 2'b10
    } state_t;

    localparam logic [19:0] WIN_LAST = 20'(WINDOW - 1);
    localparam logic [20:0] WIN_LEN  = 21'(WINDOW);
    localparam logic [7:0]  HI_LAST  = 8'(HIGH_CYC - 1);

    function automatic logic [11:0] sat_inc(input logic [11:0] val, input logic inc);
        if (inc && (val != 12'hFFF)) begin
            return val + 12'd1;
        end else begin
            return val;
        end
    endfunction

    state_t      state_r, state_s;
    logic [19:0] win_cnt_r;
    logic [20:0] acc_r, sum_s;
    logic [11:0] rate_q_r, win_pulses_r, win_pulses_s, pulse_cnt_r;
    logic        pending_r, pending_s;
    logic [7:0]  hi_cnt_r, hi_cnt_s;
    logic        speed_pulse_r;
    logic        active_s, trigger_s, win_end_s, fire_s;

    // Accumulator step, window end and pulse-launch decode
    always_comb begin
        active_s     = (state_r != IDLE) && en;
        sum_s        = acc_r + {9'd0, rate_q_r};
        trigger_s    = active_s && (sum_s >= WIN_LEN);
        win_end_s    = active_s && (win_cnt_r == WIN_LAST);
        fire_s       = (state_r == RUN_LOW) && en && (trigger_s || pending_r);
        win_pulses_s = sat_inc(win_pulses_r, fire_s);
    end

    // Next-state logic; a launch from a held trigger keeps a fresh one queued
    always_comb begin
        state_s   = state_r;
        pending_s = pending_r;
        hi_cnt_s  = hi_cnt_r;
        case (state_r)
            IDLE: begin
                pending_s = 1'b0;
                hi_cnt_s  = 8'd0;
                if (en) begin
                    state_s = RUN_LOW;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN_LOW: begin
                if (!en) begin
                    state_s   = IDLE;
                    pending_s = 1'b0;
                end else if (fire_s) begin
                    state_s   = RUN_HIGH;
                    hi_cnt_s  = 8'd0;
                    pending_s = pending_r & trigger_s;
                end else begin
                    state_s = RUN_LOW;
                end
            end
            RUN_HIGH: begin
                if (!en) begin
                    state_s   = IDLE;
                    pending_s = 1'b0;
                end else begin
                    if (trigger_s) begin
                        pending_s = 1'b1;
                    end else begin
                        pending_s = pending_r;
                    end
                    if (hi_cnt_r == HI_LAST) begin
                        state_s  = RUN_LOW;
                        hi_cnt_s = 8'd0;
                    end else begin
                        state_s  = RUN_HIGH;
                        hi_cnt_s = hi_cnt_r + 8'd1;
                    end
                end
            end
            default: begin
                state_s   = IDLE;
                pending_s = 1'b0;
                hi_cnt_s  = 8'd0;
            end
        endcase
    end

    // FSM state and registered pulse output
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            pending_r     <= 1'b0;
            hi_cnt_r      <= 8'd0;
            speed_pulse_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            pending_r     <= pending_s;
            hi_cnt_r      <= hi_cnt_s;
            speed_pulse_r <= (state_s == RUN_HIGH);
        end
    end

    // Window counter, accumulator and per-window pulse tally
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_r    <= 20'd0;
            acc_r        <= 21'd0;
            rate_q_r     <= 12'd0;
            win_pulses_r <= 12'd0;
            pulse_cnt_r  <= 12'd0;
        end else if (state_r == IDLE) begin
            if (en) begin
                rate_q_r     <= rate;
                win_cnt_r    <= 20'd0;
                acc_r        <= 21'd0;
                win_pulses_r <= 12'd0;
            end
        end else if (en) begin
            if (trigger_s) begin
                acc_r <= sum_s - WIN_LEN;
            end else begin
                acc_r <= sum_s;
            end
            if (win_end_s) begin
                win_cnt_r    <= 20'd0;
                rate_q_r     <= rate;
                pulse_cnt_r  <= win_pulses_s;
                win_pulses_r <= 12'd0;
            end else begin
                win_cnt_r    <= win_cnt_r + 20'd1;
                win_pulses_r <= win_pulses_s;
            end
        end
    end

    assign speed_pulse = speed_pulse_r;
    assign window_done = win_end_s;
    assign pulse_cnt   = pulse_cnt_r;

endmodule

// File: tb/tb_speed_pulse_gen.sv
// Bench for speed_pulse_gen (WINDOW=1000, HIGH_CYC=4): vector table, hand-written
// corner sequences and a randomized run against an arithmetic trigger model.
module tb_speed_pulse_gen;
    localparam int W  = 1000;
    localparam int HC = 4;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        en;
    logic [11:0] rate;
    logic        speed_pulse;
    logic        window_done;
    logic [11:0] pulse_cnt;

    speed_pulse_gen #(.WINDOW(W), .HIGH_CYC(HC)) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .en          (en),
        .rate        (rate),
        .speed_pulse (speed_pulse),
        .window_done (window_done),
        .pulse_cnt   (pulse_cnt)
    );

    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int rate;
        int exp_cnt;
        int exp_rise;
        int exp_rises;
        bit chk_gap;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
    endtask

    // Leave the generator idle for two cycles, then enable; next tick observes window cycle 0
    task automatic start(input int r);
        en   = 1'b0;
        rate = 12'(r);
        tick();
        tick();
        en = 1'b1;
    endtask

    // A trigger falls on window cycle k when floor((k+1)*r/W) steps up
    function automatic bit trig(input int k, input int r);
        int kk;
        kk = k % W;
        return (((kk + 1) * r) / W) != ((kk * r) / W);
    endfunction

    initial begin
        rst_n = 1'b1;
        en    = 1'b0;
        rate  = 12'd0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_speed_pulse", speed_pulse, 0);
        check("reset_window_done", window_done, 0);
        check("reset_pulse_cnt", pulse_cnt, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // rate, pulse_cnt after window, first rise cycle, rises in cycles 1..W, gap check
        vecs[0] = '{10,  10,  100,  10,  1'b1};
        vecs[1] = '{7,   7,   143,  7,   1'b1};
        vecs[2] = '{0,   0,   -1,   0,   1'b0};
        vecs[3] = '{1,   1,   1000, 1,   1'b0};
        vecs[4] = '{200, 200, 5,    200, 1'b1};
        vecs[5] = '{123, 123, 9,    123, 1'b1};
        vecs[6] = '{300, 200, 4,    200, 1'b0};

        for (int v = 0; v < 7; v++) begin
            int first_rise, rises, wd_ones, last_rise, r;
            bit prev;
            r = vecs[v].rate;
            start(r);
            first_rise = -1;
            rises      = 0;
            wd_ones    = 0;
            last_rise  = -1;
            prev       = 1'b0;
            for (int k = 0; k <= W; k++) begin
                tick();
                if (speed_pulse && !prev) begin
                    if (first_rise < 0) first_rise = k;
                    if (vecs[v].chk_gap && last_rise >= 0) begin
                        check($sformatf("gap r=%0d k=%0d", r, k),
                              int'((k - last_rise) >= (W / r) && (k - last_rise) <= ((W + r - 1) / r)), 1);
                    end
                    last_rise = k;
                    if (k >= 1) rises++;
                end
                prev = speed_pulse;
                if (window_done) wd_ones++;
                if (k == W - 1) check($sformatf("wd_last r=%0d", r), window_done, 1);
                if (k == W) check($sformatf("pulse_cnt r=%0d", r), pulse_cnt, vecs[v].exp_cnt);
            end
            check($sformatf("first_rise r=%0d", r), first_rise, vecs[v].exp_rise);
            check($sformatf("rises r=%0d", r), rises, vecs[v].exp_rises);
            check($sformatf("wd_count r=%0d", r), wd_ones, 1);
        end

        // Pending trigger: rate 300 packs pulses back to back with one low cycle between
        begin
            int pk[7];
            int pe[7];
            bit sp_log[16];
            pk = '{3, 4, 7, 8, 9, 13, 14};
            pe = '{0, 1, 1, 0, 1, 0, 1};
            start(300);
            for (int k = 0; k < 16; k++) begin
                tick();
                sp_log[k] = speed_pulse;
            end
            for (int i = 0; i < 7; i++) begin
                check($sformatf("pending_sp k=%0d", pk[i]), sp_log[pk[i]], pe[i]);
            end
        end

        // Randomized run against the arithmetic model, with a mid-window rate change
        for (int it = 0; it < 5; it++) begin
            int r0, r1, chg, exp_sp, rr;
            r0  = int'($urandom_range(0, 200));
            r1  = int'($urandom_range(0, 200));
            chg = int'($urandom_range(1, W - 2));
            start(r0);
            for (int k = 0; k < 2 * W; k++) begin
                if (k == chg) rate = 12'(r1);
                tick();
                exp_sp = 0;
                for (int d = 1; d <= HC; d++) begin
                    if (k - d >= 0) begin
                        rr = ((k - d) < W) ? r0 : r1;
                        if (trig(k - d, rr)) exp_sp = 1;
                    end
                end
                check($sformatf("rnd_sp it=%0d r=%0d/%0d k=%0d", it, r0, r1, k), speed_pulse, exp_sp);
                check($sformatf("rnd_wd it=%0d k=%0d", it, k), window_done, int'((k % W) == W - 1));
                if (k >= W) check($sformatf("rnd_pc it=%0d k=%0d", it, k), pulse_cnt, r0);
            end
        end

        // Rate change 10 -> 20 mid-window takes effect only at the boundary
        start(10);
        for (int k = 0; k <= 2 * W; k++) begin
            if (k == 500) rate = 12'd20;
            tick();
            if (k == W) check("chg_pc_win0", pulse_cnt, 10);
            if (k == 2 * W) check("chg_pc_win1", pulse_cnt, 20);
        end

        // Enable dropped mid-pulse, then at the last window cycle
        begin
            int wd_seen;
            start(10);
            for (int k = 0; k <= 101; k++) begin
                tick();
                if (k == 101) check("endrop_sp_before", speed_pulse, 1);
            end
            en = 1'b0;
            tick();
            check("endrop_sp_after", speed_pulse, 0);
            check("endrop_wd", window_done, 0);
            wd_seen = 0;
            for (int k = 0; k < 1100; k++) begin
                tick();
                if (window_done) wd_seen++;
            end
            check("endrop_no_wd", wd_seen, 0);
            check("endrop_pc_hold", pulse_cnt, 20);
            en = 1'b1;
            for (int k = 0; k < W; k++) begin
                tick();
                if (k == 99) check("reen_sp_k99", speed_pulse, 0);
                if (k == 100) check("reen_sp_k100", speed_pulse, 1);
                if (k == W - 1) check("reen_wd_last", window_done, 1);
            end
            en = 1'b0;
            tick();
            check("endrop_last_pc_hold", pulse_cnt, 20);
            check("endrop_last_sp", speed_pulse, 0);
            check("endrop_last_wd", window_done, 0);
        end

        // Asynchronous reset while a pulse is high, then a clean restart
        start(50);
        for (int k = 0; k <= W + 21; k++) begin
            tick();
            if (k == W) check("rst_pc_before", pulse_cnt, 50);
            if (k == W + 21) check("rst_sp_before", speed_pulse, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_sp", speed_pulse, 0);
        check("rst_async_wd", window_done, 0);
        check("rst_async_pc", pulse_cnt, 0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k <= W; k++) begin
            tick();
            if (k == W - 1) check("rst_pc_first_window", pulse_cnt, 0);
            if (k == W) check("rst_pc_after", pulse_cnt, 50);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
